// File: rtl/opcode_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : opcode_fetch_controller
// Purpose  : 8085-style opcode-fetch machine cycle sequencer (T1-T2-[TW]-T3-T4)
//            owning the 16-bit program counter. Drives the bus strobes and the
//            one-cycle instruction-register load pulse. The decoder holds T4
//            through i_stall and requests HALT through i_halt_req.
// Config   : `define WAIT_STATE_EN enables TW wait states driven by i_ready,
//            a wait counter and the bus_err time-out. When the macro is not
//            defined, i_ready is ignored and o_bus_err is tied low.
// Ports    : clk          in   system clock, rising edge
//            reset        in   synchronous active-high reset
//            i_ready      in   memory ready (WAIT_STATE_EN only)
//            i_stall      in   hold T4 while high
//            i_halt_req   in   HLT indication, sampled in T4
//            i_wake       in   leave HALT
//            i_pc_load    in   load PC from i_pc_in
//            i_pc_in      in   [15:0] new PC value
//            o_addr_out   out  [15:0] address bus, PC latched entering T1
//            o_ale        out  address latch enable, high in T1
//            o_rd_n       out  read strobe, active low (T2/TW/T3)
//            o_io_m       out  0 = memory cycle, always 0 here
//            o_s1s0       out  [1:0] 11 during fetch, 00 in IDLE/HALT
//            o_ir_load    out  one-cycle pulse in T3
//            o_t_state    out  [2:0] 0=IDLE 1=T1 2=T2 3=T3 4=T4 5=TW 6=HALT
//            o_bus_err    out  one-cycle pulse on wait time-out
// Revision : 1.0  initial release
// ============================================================================
module opcode_fetch_controller #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          MAX_WAIT     = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_ready,
  input  logic        i_stall,
  input  logic        i_halt_req,
  input  logic        i_wake,
  input  logic        i_pc_load,
  input  logic [15:0] i_pc_in,
  output logic [15:0] o_addr_out,
  output logic        o_ale,
  output logic        o_rd_n,
  output logic        o_io_m,
  output logic [1:0]  o_s1s0,
  output logic        o_ir_load,
  output logic [2:0]  o_t_state,
  output logic        o_bus_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_TW   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_bus_err;
  logic [15:0] r_pc;

`ifdef WAIT_STATE_EN
  localparam int unsigned c_CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [c_CW-1:0] c_MAX_WAIT = MAX_WAIT[c_CW-1:0];
  logic [c_CW-1:0] r_wait_cnt;
`else
  // Ready and the time-out limit have no function without wait states.
  logic [1:0] w_unused_cfg;
  assign w_unused_cfg = {i_ready, (MAX_WAIT > 0)};
`endif

  // Next-state logic
  always_comb begin
    w_next    = r_state;
    w_bus_err = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_T1;
      S_T1:   w_next = S_T2;
`ifdef WAIT_STATE_EN
      S_T2:   w_next = i_ready ? S_T3 : S_TW;
      S_TW: begin
        if (i_ready) begin
          w_next = S_T3;
        end else if (r_wait_cnt == c_MAX_WAIT) begin
          // Memory never answered: abandon the wait and flag it.
          w_next    = S_T3;
          w_bus_err = 1'b1;
        end else begin
          w_next = S_TW;
        end
      end
`else
      S_T2:   w_next = S_T3;
`endif
      S_T3:   w_next = S_T4;
      // Stall has priority, so halt_req is only acted on once stall drops.
      S_T4: begin
        if (i_stall)         w_next = S_T4;
        else if (i_halt_req) w_next = S_HALT;
        else                 w_next = S_T1;
      end
      S_HALT: w_next = i_wake ? S_T1 : S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  // State, PC and registered outputs. Outputs are decoded from the next state
  // so that they are valid during the cycle in which that state is current.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_VECTOR;
      o_addr_out <= 16'h0000;
      o_ale      <= 1'b0;
      o_rd_n     <= 1'b1;
      o_s1s0     <= 2'b00;
      o_ir_load  <= 1'b0;
      o_bus_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (i_pc_load)           r_pc <= i_pc_in;
      else if (r_state == S_T2) r_pc <= r_pc + 16'd1;
      if (w_next == S_T1)      o_addr_out <= r_pc;
      o_ale     <= (w_next == S_T1);
      o_rd_n    <= !((w_next == S_T2) || (w_next == S_T3) || (w_next == S_TW));
      o_s1s0    <= ((w_next == S_IDLE) || (w_next == S_HALT)) ? 2'b00 : 2'b11;
      o_ir_load <= (w_next == S_T3);
      o_bus_err <= w_bus_err;
    end
  end

`ifdef WAIT_STATE_EN
  always_ff @(posedge clk) begin
    if (reset)               r_wait_cnt <= '0;
    else if (w_next == S_TW) r_wait_cnt <= r_wait_cnt + 1'b1;
    else                     r_wait_cnt <= '0;
  end
`endif

  assign o_io_m    = 1'b0;
  assign o_t_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_opcode_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_opcode_fetch_controller
// Purpose  : Self-checking bench for opcode_fetch_controller. A table of
//            per-cycle input/expected records covers reset, fetch sequencing,
//            PC wrap and load priority, stall/halt/wake and reset in T2. Short
//            hand-written sequences cover free-running address order and,
//            with WAIT_STATE_EN, wait states and the bus_err time-out.
// Revision : 1.0  initial release
// ============================================================================
module tb_opcode_fetch_controller;

  logic        clk = 1'b0;
  logic        reset, ready, stall, halt_req, wake, pc_load;
  logic [15:0] pc_in;
  logic [15:0] addr_out;
  logic        ale, rd_n, io_m, ir_load, bus_err;
  logic [1:0]  s1s0;
  logic [2:0]  t_state;

  always #5 clk = ~clk;

  opcode_fetch_controller #(.RESET_VECTOR(16'h0000), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .i_ready(ready), .i_stall(stall),
    .i_halt_req(halt_req), .i_wake(wake), .i_pc_load(pc_load),
    .i_pc_in(pc_in), .o_addr_out(addr_out), .o_ale(ale), .o_rd_n(rd_n),
    .o_io_m(io_m), .o_s1s0(s1s0), .o_ir_load(ir_load),
    .o_t_state(t_state), .o_bus_err(bus_err)
  );

  typedef struct {
    logic        rst, stl, hlt, wk, ld;
    logic [15:0] pin;
    logic [2:0]  t;
    logic [15:0] a;
  } vec_t;

  typedef logic [25:0] obs_t;

  vec_t        tbl[$];
  obs_t        sb[$];
  logic [15:0] addr_q[$];
  int          checks   = 0;
  int          failures = 0;

  // Expected outputs for a given state, address and bus_err level.
  function automatic obs_t expect_of(input logic [2:0] t, input logic [15:0] a,
                                     input logic be);
    logic       e_ale, e_rdn, e_irl;
    logic [1:0] e_s;
    e_ale = (t == 3'd1);
    e_rdn = !((t == 3'd2) || (t == 3'd3) || (t == 3'd5));
    e_s   = ((t >= 3'd1) && (t <= 3'd5)) ? 2'b11 : 2'b00;
    e_irl = (t == 3'd3);
    return {t, a, e_ale, e_rdn, e_s, e_irl, be, 1'b0};
  endfunction

  function automatic obs_t observe();
    return {t_state, addr_out, ale, rd_n, s1s0, ir_load, bus_err, io_m};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got{t,addr,ale,rdn,s,irl,be,iom}=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic add(input logic rst, stl, hlt, wk, ld, input logic [15:0] pin,
                     input logic [2:0] t, input logic [15:0] a);
    tbl.push_back('{rst, stl, hlt, wk, ld, pin, t, a});
  endtask

  task automatic idle_inputs();
    reset = 1'b0; stall = 1'b0; halt_req = 1'b0; wake = 1'b0;
    pc_load = 1'b0; pc_in = 16'h0000; ready = 1'b1;
  endtask

  // Bounded wait for a given state, sampled 1 ns after each rising edge.
  task automatic wait_state(input logic [2:0] t, input string name);
    int n;
    n = 0;
    while (t_state !== t && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (t_state !== t) begin
      checks++; failures++;
      $display("FAIL %s timeout got_t=%0d expected_t=%0d", name, t_state, t);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;

    //   rst stl hlt wk ld pin       t     addr
    add(1, 0, 0, 0, 0, 16'h0000, 3'd0, 16'h0000);   // reset held 3 clk
    add(1, 0, 0, 0, 0, 16'h0000, 3'd0, 16'h0000);
    add(1, 0, 0, 0, 0, 16'h0000, 3'd0, 16'h0000);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd1, 16'h0000);   // T1 fetch 0000
    add(0, 0, 0, 0, 0, 16'h0000, 3'd2, 16'h0000);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd3, 16'h0000);   // ir_load
    add(0, 0, 0, 0, 0, 16'h0000, 3'd4, 16'h0000);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd1, 16'h0001);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd2, 16'h0001);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd3, 16'h0001);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd4, 16'h0001);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd1, 16'h0002);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd2, 16'h0002);
    add(0, 0, 0, 0, 1, 16'hFFFF, 3'd3, 16'h0002);   // load in T2 beats increment
    add(0, 0, 0, 0, 0, 16'h0000, 3'd4, 16'h0002);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd1, 16'hFFFF);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd2, 16'hFFFF);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd3, 16'hFFFF);   // pc wraps to 0000
    add(0, 0, 0, 0, 0, 16'h0000, 3'd4, 16'hFFFF);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd1, 16'h0000);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd2, 16'h0000);
    add(0, 0, 0, 0, 1, 16'h1234, 3'd3, 16'h0000);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd4, 16'h0000);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd1, 16'h1234);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd2, 16'h1234);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd3, 16'h1234);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd4, 16'h1234);
    add(0, 1, 0, 0, 0, 16'h0000, 3'd4, 16'h1234);   // stall x3
    add(0, 1, 0, 0, 0, 16'h0000, 3'd4, 16'h1234);
    add(0, 1, 1, 0, 0, 16'h0000, 3'd4, 16'h1234);   // stall beats halt
    add(0, 0, 1, 0, 0, 16'h0000, 3'd6, 16'h1234);   // HALT
    add(0, 0, 0, 0, 0, 16'h0000, 3'd6, 16'h1234);
    add(0, 0, 0, 1, 0, 16'h0000, 3'd1, 16'h1235);   // wake
    add(0, 0, 0, 0, 0, 16'h0000, 3'd2, 16'h1235);
    add(1, 0, 0, 0, 0, 16'h0000, 3'd0, 16'h0000);   // reset in T2
    add(0, 0, 0, 0, 0, 16'h0000, 3'd1, 16'h0000);
    add(0, 0, 0, 0, 0, 16'h0000, 3'd2, 16'h0000);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst; stall = tbl[i].stl; halt_req = tbl[i].hlt;
      wake = tbl[i].wk; pc_load = tbl[i].ld; pc_in = tbl[i].pin;
      sb.push_back(expect_of(tbl[i].t, tbl[i].a, 1'b0));
      @(posedge clk); #1;
      check($sformatf("row%0d", i), observe(), sb.pop_front());
    end

    // Free-running fetches: addresses must appear in order on each ale.
    begin
      int irl_cnt;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); idle_inputs();
      for (int k = 0; k < 5; k++) addr_q.push_back(16'(k));
      irl_cnt = 0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (ir_load) irl_cnt++;
        if (ale) begin
          if (addr_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL freerun_extra_ale got=%h expected=none", addr_out);
          end else begin
            check_int("freerun_addr", int'(addr_out), int'(addr_q.pop_front()));
          end
        end
      end
      check_int("freerun_leftover", addr_q.size(), 0);
      check_int("freerun_irl_count", irl_cnt, 5);
    end

`ifdef WAIT_STATE_EN
    begin
      int tw;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); idle_inputs();
      @(posedge clk); #1;
      wait_state(3'd2, "ws_reach_t2");
      @(negedge clk); ready = 1'b0;
      @(posedge clk); #1; check("ws_tw1", observe(), expect_of(3'd5, 16'h0000, 1'b0));
      @(negedge clk);
      @(posedge clk); #1; check("ws_tw2", observe(), expect_of(3'd5, 16'h0000, 1'b0));
      @(negedge clk); ready = 1'b1;
      @(posedge clk); #1; check("ws_t3", observe(), expect_of(3'd3, 16'h0000, 1'b0));
      wait_state(3'd2, "ws_reach_t2b");
      @(negedge clk); ready = 1'b0;
      tw = 0;
      @(posedge clk); #1;
      while (t_state === 3'd5 && tw < 40) begin
        tw++;
        @(posedge clk); #1;
      end
      check_int("ws_tw_count", tw, 15);
      check("ws_timeout_t3", observe(), expect_of(3'd3, 16'h0001, 1'b1));
      @(posedge clk); #1;
      check("ws_after_err", observe(), expect_of(3'd4, 16'h0001, 1'b0));
      ready = 1'b1;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
